replica_exchange_unit: RTL and testbench

Per-replica exchange-decision engine for the replica-exchange annealer, the parametrised successor of the single-width replica test stage. One instance per replica. It computes the energy difference for the current pairing phase, runs the Metropolis acceptance test through a request/acknowledge handshake to a shared exp unit, exchanges decisions with its neighbours, and issues one `exchange_command_t` per trial. Optional acceptance statistics are included.

---
 rtl/replica_exchange_unit.sv | 214 +++++++++++++++++++++
 tb/tb_replica_exchange_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/replica_exchange_unit.sv
// replica_exchange_unit
//   Per-replica exchange-decision engine for the replica-exchange annealer.
//   On each trial the replica either runs the Metropolis test against its
//   follower (lower member), waits for its predecessor's decision (upper
//   member), or issues SELF directly (edge role), then strobes one command.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   start                 one-cycle trial start (ignored while busy)
//   phase                 pairing phase; lower member when ID%2 == phase
//   self_e/prev_e/folw_e  unsigned replica energies
//   rand_th               random acceptance threshold
//   exp_req/exp_x         request and argument to the shared exp unit
//   exp_ack/exp_y         exp unit result strobe and value
//   prev_accept(_valid)   decision from the previous replica
//   out_accept(_valid)    decision forwarded to the follower replica
//   shift_d               forces cmd to PREV combinationally
//   cmd/cmd_valid         exchange command and strobe
//                         (encoding: 0=NOP, 1=SELF, 2=PREV, 3=FOLW)
//   busy                  trial in progress
//   cnt_clear             synchronous clear of the statistics counters
//   accept_cnt/trial_cnt  saturating statistics counters
//
// Configuration
//   REPLICA_EXCHANGE_STATS_EN  when defined, the statistics counters are
//                              built; otherwise they read 0 and cnt_clear
//                              has no effect.
module replica_exchange_unit #(
    parameter int ID          = 0,
    parameter int REPLICA_NUM = 32,
    parameter int E_WIDTH     = 32,
    parameter int X_WIDTH     = 21,
    parameter int P_WIDTH     = 27,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 phase,
    input  logic [E_WIDTH-1:0]   self_e,
    input  logic [E_WIDTH-1:0]   prev_e,
    input  logic [E_WIDTH-1:0]   folw_e,
    input  logic [P_WIDTH-1:0]   rand_th,
    output logic                 exp_req,
    output logic [X_WIDTH-1:0]   exp_x,
    input  logic                 exp_ack,
    input  logic [P_WIDTH-1:0]   exp_y,
    input  logic                 prev_accept,
    input  logic                 prev_accept_valid,
    output logic                 out_accept,
    output logic                 out_accept_valid,
    input  logic                 shift_d,
    output logic [1:0]           cmd,
    output logic                 cmd_valid,
    output logic                 busy,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] accept_cnt,
    output logic [CNT_WIDTH-1:0] trial_cnt
);

    typedef enum logic [2:0] {IDLE, TEST, EXP_WAIT, WAIT_PEER, ISSUE} state_t;
    typedef enum logic [1:0] {CMD_NOP, CMD_SELF, CMD_PREV, CMD_FOLW} exchange_command_t;

    localparam logic ID_PARITY = 1'(ID % 2);
    localparam bit   HAS_FOLW  = (ID < REPLICA_NUM - 1);
    localparam bit   HAS_PRED  = (ID > 0);
    localparam logic [E_WIDTH-1:0] X_LIMIT = {{(E_WIDTH-1){1'b0}}, 1'b1} << X_WIDTH;

    state_t            state;
    exchange_command_t cmd_q;
    logic              accept_q;
    logic              tester_q;     // this trial runs the test (counts in statistics)
    logic              peer_valid;
    logic              peer_accept;

    logic [E_WIDTH:0]  delta;
    logic              delta_nonpos;
    logic              delta_sat;
    logic              exp_pass;
    logic              peer_now;
    logic              peer_acc_now;
    logic              is_lower;

    always_comb begin
        delta        = {1'b0, folw_e} - {1'b0, self_e};
        delta_nonpos = delta[E_WIDTH] || (delta == '0);
        delta_sat    = !delta[E_WIDTH] && (delta[E_WIDTH-1:0] >= X_LIMIT);
        exp_pass     = exp_y > rand_th;
        // A decision arriving this cycle is used directly if the latch is empty.
        peer_now     = peer_valid || prev_accept_valid;
        peer_acc_now = peer_valid ? peer_accept : prev_accept;
        is_lower     = (phase == ID_PARITY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cmd_q            <= CMD_NOP;
            cmd_valid        <= 1'b0;
            exp_req          <= 1'b0;
            exp_x            <= '0;
            out_accept       <= 1'b0;
            out_accept_valid <= 1'b0;
            busy             <= 1'b0;
            accept_q         <= 1'b0;
            tester_q         <= 1'b0;
            peer_valid       <= 1'b0;
            peer_accept      <= 1'b0;
        end else begin
            cmd_q            <= CMD_NOP;
            cmd_valid        <= 1'b0;
            out_accept       <= 1'b0;
            out_accept_valid <= 1'b0;

            if (prev_accept_valid) begin
                peer_valid  <= 1'b1;
                peer_accept <= prev_accept;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        accept_q <= 1'b0;
                        tester_q <= is_lower && HAS_FOLW;
                        if (is_lower && HAS_FOLW) begin
                            state <= TEST;
                        end else if (!is_lower && HAS_PRED) begin
                            state <= WAIT_PEER;
                        end else begin
                            state     <= ISSUE;
                            cmd_valid <= 1'b1;
                            cmd_q     <= CMD_SELF;
                        end
                    end
                end
                TEST: begin
                    if (delta_nonpos || delta_sat) begin
                        state            <= ISSUE;
                        accept_q         <= delta_nonpos;
                        cmd_valid        <= 1'b1;
                        cmd_q            <= delta_nonpos ? CMD_FOLW : CMD_SELF;
                        out_accept_valid <= 1'b1;
                        out_accept       <= delta_nonpos;
                    end else begin
                        state   <= EXP_WAIT;
                        exp_req <= 1'b1;
                        exp_x   <= delta[X_WIDTH-1:0];
                    end
                end
                EXP_WAIT: begin
                    if (exp_ack) begin
                        state            <= ISSUE;
                        exp_req          <= 1'b0;
                        accept_q         <= exp_pass;
                        cmd_valid        <= 1'b1;
                        cmd_q            <= exp_pass ? CMD_FOLW : CMD_SELF;
                        out_accept_valid <= 1'b1;
                        out_accept       <= exp_pass;
                    end
                end
                WAIT_PEER: begin
                    if (peer_now) begin
                        state      <= ISSUE;
                        peer_valid <= 1'b0;
                        accept_q   <= peer_acc_now;
                        cmd_valid  <= 1'b1;
                        cmd_q      <= peer_acc_now ? CMD_PREV : CMD_SELF;
                    end
                end
                ISSUE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmd = shift_d ? CMD_PREV : cmd_q;
    end

    logic unused_inputs;
    assign unused_inputs = ^prev_e;

`ifdef REPLICA_EXCHANGE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accept_cnt <= '0;
            trial_cnt  <= '0;
        end else if (cnt_clear) begin
            accept_cnt <= '0;
            trial_cnt  <= '0;
        end else if (state == ISSUE && tester_q) begin
            if (trial_cnt != '1) begin
                trial_cnt <= trial_cnt + CNT_WIDTH'(1);
            end
            if (accept_q && accept_cnt != '1) begin
                accept_cnt <= accept_cnt + CNT_WIDTH'(1);
            end
        end
    end
`else
    always_comb begin
        accept_cnt = '0;
        trial_cnt  = '0;
    end

    logic stats_unused;
    assign stats_unused = cnt_clear ^ accept_q ^ tester_q;
`endif

endmodule

// File: tb/tb_replica_exchange_unit.sv
// Testbench for replica_exchange_unit: a main replica (ID=2 of 8, 4-bit
// counters) exercised as lower and upper member, plus two edge replicas
// (ID=7 and ID=0) whose SELF issue is checked in phase 1.
module tb_replica_exchange_unit;

    localparam int EW = 32;
    localparam int XW = 21;
    localparam int PW = 27;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    localparam logic [1:0] C_NOP  = 2'd0;
    localparam logic [1:0] C_SELF = 2'd1;
    localparam logic [1:0] C_PREV = 2'd2;
    localparam logic [1:0] C_FOLW = 2'd3;

`ifdef REPLICA_EXCHANGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          phase = 1'b0;
    logic [EW-1:0] self_e = '0;
    logic [EW-1:0] prev_e = '0;
    logic [EW-1:0] folw_e = '0;
    logic [PW-1:0] rand_th = '0;
    logic          exp_ack = 1'b0;
    logic [PW-1:0] exp_y = '0;
    logic          prev_accept = 1'b0;
    logic          prev_accept_valid = 1'b0;
    logic          shift_d = 1'b0;
    logic          cnt_clear = 1'b0;

    logic          exp_req;
    logic [XW-1:0] exp_x;
    logic          out_accept;
    logic          out_accept_valid;
    logic [1:0]    cmd;
    logic          cmd_valid;
    logic          busy;
    logic [CW-1:0] accept_cnt;
    logic [CW-1:0] trial_cnt;

    logic          hi_exp_req, lo_exp_req;
    logic [XW-1:0] hi_exp_x, lo_exp_x;
    logic          hi_oa, lo_oa, hi_oav, lo_oav;
    logic [1:0]    hi_cmd, lo_cmd;
    logic          hi_cmd_valid, lo_cmd_valid;
    logic          hi_busy, lo_busy;
    logic [CW-1:0] hi_acc, lo_acc, hi_tri, lo_tri;

    int checks = 0;
    int failures = 0;
    int m_acc = 0;
    int m_tri = 0;

    always #5 clk = ~clk;

    replica_exchange_unit #(.ID(2), .REPLICA_NUM(8), .E_WIDTH(EW), .X_WIDTH(XW),
                            .P_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .phase(phase),
        .self_e(self_e), .prev_e(prev_e), .folw_e(folw_e), .rand_th(rand_th),
        .exp_req(exp_req), .exp_x(exp_x), .exp_ack(exp_ack), .exp_y(exp_y),
        .prev_accept(prev_accept), .prev_accept_valid(prev_accept_valid),
        .out_accept(out_accept), .out_accept_valid(out_accept_valid),
        .shift_d(shift_d), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .cnt_clear(cnt_clear), .accept_cnt(accept_cnt), .trial_cnt(trial_cnt));

    // Edge replicas: exp and peer handshakes tied active so they never stall.
    replica_exchange_unit #(.ID(7), .REPLICA_NUM(8), .E_WIDTH(EW), .X_WIDTH(XW),
                            .P_WIDTH(PW), .CNT_WIDTH(CW)) u_hi (
        .clk(clk), .reset(reset), .start(start), .phase(phase),
        .self_e(self_e), .prev_e(prev_e), .folw_e(folw_e), .rand_th(rand_th),
        .exp_req(hi_exp_req), .exp_x(hi_exp_x), .exp_ack(1'b1), .exp_y(exp_y),
        .prev_accept(1'b0), .prev_accept_valid(1'b1),
        .out_accept(hi_oa), .out_accept_valid(hi_oav),
        .shift_d(1'b0), .cmd(hi_cmd), .cmd_valid(hi_cmd_valid), .busy(hi_busy),
        .cnt_clear(1'b0), .accept_cnt(hi_acc), .trial_cnt(hi_tri));

    replica_exchange_unit #(.ID(0), .REPLICA_NUM(8), .E_WIDTH(EW), .X_WIDTH(XW),
                            .P_WIDTH(PW), .CNT_WIDTH(CW)) u_lo (
        .clk(clk), .reset(reset), .start(start), .phase(phase),
        .self_e(self_e), .prev_e(prev_e), .folw_e(folw_e), .rand_th(rand_th),
        .exp_req(lo_exp_req), .exp_x(lo_exp_x), .exp_ack(1'b1), .exp_y(exp_y),
        .prev_accept(1'b0), .prev_accept_valid(1'b1),
        .out_accept(lo_oa), .out_accept_valid(lo_oav),
        .shift_d(1'b0), .cmd(lo_cmd), .cmd_valid(lo_cmd_valid), .busy(lo_busy),
        .cnt_clear(1'b0), .accept_cnt(lo_acc), .trial_cnt(lo_tri));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_trial_cnt"}, 64'(trial_cnt), STATS ? 64'(m_tri) : 64'd0);
        chk({tag, "_accept_cnt"}, 64'(accept_cnt), STATS ? 64'(m_acc) : 64'd0);
    endtask

    // Lower-member trial: the expected outcome is derived from the Metropolis
    // rule on the integer energy difference.
    task automatic lower_trial(input logic [EW-1:0] se, input logic [EW-1:0] fe,
                               input logic [PW-1:0] rth, input logic [PW-1:0] ey,
                               input int ack_cyc, input bit clr, input bit sh);
        longint d;
        bit     use_exp;
        bit     acc;
        int     issue_cyc;
        int     cyc;
        d         = longint'(fe) - longint'(se);
        use_exp   = (d > 0) && (d < (longint'(1) << XW));
        acc       = (d <= 0) || (use_exp && (ey > rth));
        issue_cyc = use_exp ? ack_cyc + 1 : 2;

        phase = 1'b0; self_e = se; folw_e = fe; rand_th = rth; exp_y = ey;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < issue_cyc) begin
            chk("lo_busy_wait", 64'(busy), 64'd1);
            chk("lo_cmd_valid_wait", 64'(cmd_valid), 64'd0);
            if (cyc == 1) begin
                chk("lo_exp_req_c1", 64'(exp_req), 64'd0);
            end else begin
                chk("lo_exp_req_hold", 64'(exp_req), 64'd1);
                chk("lo_exp_x_hold", 64'(exp_x), 64'(d));
            end
            if (use_exp && cyc == ack_cyc) exp_ack = 1'b1;
            @(negedge clk);
            exp_ack = 1'b0;
            cyc++;
        end
        shift_d   = sh;
        cnt_clear = clr;
        #1;
        chk("lo_issue_valid", 64'(cmd_valid), 64'd1);
        chk("lo_issue_cmd", 64'(cmd), sh ? 64'(C_PREV) : (acc ? 64'(C_FOLW) : 64'(C_SELF)));
        chk("lo_out_accept_valid", 64'(out_accept_valid), 64'd1);
        chk("lo_out_accept", 64'(out_accept), 64'(acc));
        chk("lo_issue_exp_req", 64'(exp_req), 64'd0);
        chk("lo_issue_busy", 64'(busy), 64'd1);
        if (clr) begin
            m_tri = 0; m_acc = 0;
        end else begin
            if (m_tri < CNT_MAX) m_tri++;
            if (acc && m_acc < CNT_MAX) m_acc++;
        end
        @(negedge clk);
        shift_d = 1'b0; cnt_clear = 1'b0;
        #1;
        chk("lo_after_valid", 64'(cmd_valid), 64'd0);
        chk("lo_after_busy", 64'(busy), 64'd0);
        chk("lo_after_cmd", 64'(cmd), 64'(C_NOP));
        chk_counters("lo_after");
        @(negedge clk);
    endtask

    // Upper-member trial; pv_cyc <= 0 delivers the peer decision before start.
    task automatic upper_trial(input bit pa, input int pv_cyc);
        int issue_cyc;
        int cyc;
        phase = 1'b1;
        if (pv_cyc <= 0) begin
            prev_accept = pa; prev_accept_valid = 1'b1;
            @(negedge clk);
            prev_accept_valid = 1'b0;
            @(negedge clk);
        end
        issue_cyc = (pv_cyc <= 0) ? 2 : pv_cyc + 1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("edge7_valid_c1", 64'(hi_cmd_valid), 64'd1);
        chk("edge7_cmd_c1", 64'(hi_cmd), 64'(C_SELF));
        chk("edge0_valid_c1", 64'(lo_cmd_valid), 64'd1);
        chk("edge0_cmd_c1", 64'(lo_cmd), 64'(C_SELF));
        cyc = 1;
        while (cyc < issue_cyc) begin
            chk("up_busy_wait", 64'(busy), 64'd1);
            chk("up_cmd_valid_wait", 64'(cmd_valid), 64'd0);
            if (cyc == pv_cyc) begin
                prev_accept = pa; prev_accept_valid = 1'b1;
            end
            @(negedge clk);
            prev_accept_valid = 1'b0;
            cyc++;
        end
        chk("up_issue_valid", 64'(cmd_valid), 64'd1);
        chk("up_issue_cmd", 64'(cmd), pa ? 64'(C_PREV) : 64'(C_SELF));
        chk("up_out_accept_valid", 64'(out_accept_valid), 64'd0);
        @(negedge clk);
        chk("up_after_busy", 64'(busy), 64'd0);
        chk("up_after_valid", 64'(cmd_valid), 64'd0);
        chk_counters("up_after");
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EW-1:0] se;
        logic [EW-1:0] fe;
        logic [PW-1:0] rth;
        logic [PW-1:0] ey;
        int            kind;

        repeat (3) @(negedge clk);
        chk("rst_exp_req", 64'(exp_req), 64'd0);
        chk("rst_exp_x", 64'(exp_x), 64'd0);
        chk("rst_cmd", 64'(cmd), 64'(C_NOP));
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_accept", 64'(out_accept), 64'd0);
        chk("rst_out_accept_valid", 64'(out_accept_valid), 64'd0);
        chk_counters("rst");
        reset = 1'b1;
        @(negedge clk);

        // Directed lower-member cases.
        lower_trial(32'd100, 32'd90, 27'd0, 27'd0, 0, 1'b0, 1'b0);
        lower_trial(32'd1000, 32'd1050, 27'd1000, 27'd2000, 5, 1'b0, 1'b0);
        lower_trial(32'd1000, 32'd1050, 27'd1000, 27'd1000, 3, 1'b0, 1'b0);
        lower_trial(32'd5, 32'd5 + (32'd1 << XW), 27'd0, 27'h7FF_FFFF, 2, 1'b0, 1'b0);
        lower_trial(32'd5, 32'd4 + (32'd1 << XW), 27'd0, 27'd1, 2, 1'b0, 1'b0);
        lower_trial(32'd7, 32'd7, 27'd0, 27'd0, 0, 1'b0, 1'b1);

        // Directed upper-member cases (also covers both edge replicas).
        upper_trial(1'b1, 4);
        upper_trial(1'b1, 0);
        upper_trial(1'b0, 2);
        upper_trial(1'b0, 1);

        // shift_d while idle.
        shift_d = 1'b1;
        #1;
        chk("shift_idle_cmd", 64'(cmd), 64'(C_PREV));
        chk("shift_idle_valid", 64'(cmd_valid), 64'd0);
        shift_d = 1'b0;
        #1;
        chk("shift_off_cmd", 64'(cmd), 64'(C_NOP));
        @(negedge clk);

        // Randomized lower-member trials.
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            rth  = PW'($urandom);
            ey   = PW'($urandom);
            se   = $urandom_range(0, 32'h7FFF_FFFF);
            case (kind)
                0: begin
                    se = $urandom;
                    fe = $urandom_range(0, se);
                end
                1: fe = se + $urandom_range(32'd1 << XW, 32'h7000_0000);
                2: fe = se + $urandom_range(1, (32'd1 << XW) - 1);
                default: begin
                    fe = se + $urandom_range(1, (32'd1 << XW) - 1);
                    ey = rth;
                end
            endcase
            lower_trial(se, fe, rth, ey, int'($urandom_range(2, 6)), 1'b0,
                        ($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < 6; i++) begin
            upper_trial(1'($urandom), int'($urandom_range(0, 5)));
        end

        // Reset asserted while waiting on the exp unit.
        phase = 1'b0; self_e = 32'd1000; folw_e = 32'd1300;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstw_exp_req_before", 64'(exp_req), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstw_exp_req_async", 64'(exp_req), 64'd0);
        chk("rstw_busy_async", 64'(busy), 64'd0);
        m_tri = 0; m_acc = 0;
        @(negedge clk);
        reset = 1'b1;
        exp_ack = 1'b1;
        @(negedge clk);
        exp_ack = 1'b0;
        chk("rstw_late_ack_valid", 64'(cmd_valid), 64'd0);
        chk("rstw_late_ack_busy", 64'(busy), 64'd0);
        chk("rstw_late_ack_req", 64'(exp_req), 64'd0);
        chk_counters("rstw");
        @(negedge clk);
        lower_trial(32'd1000, 32'd1300, 27'd10, 27'd20, 3, 1'b0, 1'b0);

        // Counter saturation with accepted trials.
        for (int i = 0; i < 18; i++) begin
            se = $urandom;
            fe = $urandom_range(0, se);
            lower_trial(se, fe, 27'd0, 27'd0, 0, 1'b0, 1'b0);
        end

        // Clear coincident with the issue cycle.
        lower_trial(32'd50, 32'd40, 27'd0, 27'd0, 0, 1'b1, 1'b0);
        lower_trial(32'd50, 32'd60, 27'd5, 27'd9, 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
